// File: rtl/cc_branch_unit_if.sv
// Bundle of the ALU-flag, branch-request and branch-result signals that
// connect the branch unit to the pipeline. The pipeline drives the request
// side through the master modport; the branch unit uses the slave modport.
interface cc_branch_unit_if;
  logic [3:0] alu_flags;  // {Z,N,C,V} straight from the ALU
  logic       cc_we;
  logic       stall;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_annul;
  logic [3:0] icc;        // {N,Z,V,C}
  logic       br_taken;
  logic       annul_ds;
  logic       br_done;
  logic       dcti_err;

  modport master (
    output alu_flags, cc_we, stall, br_valid, br_cond, br_annul,
    input  icc, br_taken, annul_ds, br_done, dcti_err
  );

  modport slave (
    input  alu_flags, cc_we, stall, br_valid, br_cond, br_annul,
    output icc, br_taken, annul_ds, br_done, dcti_err
  );
endinterface

// File: rtl/cc_branch_unit.sv
// Integer condition-code register and Bicc resolver. Holds icc {N,Z,V,C},
// resolves branch conditions with a same-cycle bypass from the ALU flags,
// and tracks the delay slot with a two-state FSM. All outputs registered.
module cc_branch_unit (
  input  logic                  clk,
  input  logic                  rst_n,
  cc_branch_unit_if.slave       bus
);

  typedef enum logic {S_IDLE, S_SLOT} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_icc;
  logic       r_br_taken, r_annul_ds, r_br_done, r_dcti_err;
  logic       w_br_taken_nxt, w_annul_ds_nxt, w_br_done_nxt, w_dcti_err_nxt;
  logic       w_adv;
  logic [3:0] w_alu_icc;   // alu_flags reordered into icc layout
  logic [3:0] w_f;         // effective flags for evaluation, icc layout
  logic       w_taken;
  logic       w_annul;

  // Evaluate a Bicc condition against flags in {N,Z,V,C} layout; the upper
  // half of the encoding is the complement of the lower half.
  function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, t;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (cond[2:0])
      3'd0:    t = 1'b0;
      3'd1:    t = z;
      3'd2:    t = z | (n ^ v);
      3'd3:    t = n ^ v;
      3'd4:    t = c | z;
      3'd5:    t = c;
      3'd6:    t = n;
      default: t = v;
    endcase
    return cond[3] ? ~t : t;
  endfunction

  assign w_adv     = ~bus.stall;
  assign w_alu_icc = {bus.alu_flags[2], bus.alu_flags[3], bus.alu_flags[0], bus.alu_flags[1]};
  assign w_f       = bus.cc_we ? w_alu_icc : r_icc;
  assign w_taken   = cond_taken(bus.br_cond, w_f);
  // BA,a annuls despite being taken; any untaken annulling branch annuls.
  assign w_annul   = bus.br_annul & ((bus.br_cond == 4'b1000) | ~w_taken);

  // Architectural icc: written by any cc-modifying op regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icc <= 4'b0000;
    end else if (bus.cc_we && w_adv) begin
      r_icc <= w_alu_icc;
    end
  end

  // FSM state and registered branch outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_br_taken <= 1'b0;
      r_annul_ds <= 1'b0;
      r_br_done  <= 1'b0;
      r_dcti_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_br_taken <= w_br_taken_nxt;
      r_annul_ds <= w_annul_ds_nxt;
      r_br_done  <= w_br_done_nxt;
      r_dcti_err <= w_dcti_err_nxt;
    end
  end

  // Next state and outputs; a stall holds every register, pulses included.
  always_comb begin
    w_state_nxt    = r_state;
    w_br_taken_nxt = r_br_taken;
    w_annul_ds_nxt = r_annul_ds;
    w_br_done_nxt  = r_br_done;
    w_dcti_err_nxt = r_dcti_err;
    if (w_adv) begin
      w_br_done_nxt  = 1'b0;
      w_dcti_err_nxt = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.br_valid) begin
            w_br_taken_nxt = w_taken;
            w_annul_ds_nxt = w_annul;
            w_br_done_nxt  = 1'b1;
            w_state_nxt    = S_SLOT;
          end
        end
        default: begin
          // Delay-slot instruction leaves decode; a branch here is a DCTI
          // couple and is dropped with an error pulse.
          w_br_taken_nxt = 1'b0;
          w_annul_ds_nxt = 1'b0;
          w_dcti_err_nxt = bus.br_valid;
          w_state_nxt    = S_IDLE;
        end
      endcase
    end
  end

  assign bus.icc      = r_icc;
  assign bus.br_taken = r_br_taken;
  assign bus.annul_ds = r_annul_ds;
  assign bus.br_done  = r_br_done;
  assign bus.dcti_err = r_dcti_err;

endmodule
